// File: rtl/tetris_pkg.sv
// Shared playfield constants, score table and scanner state type.
//   BG_COLOR  : colour word of an empty cell
//   ROWS/COLS : default playfield geometry
//   SCORE_n   : points awarded for n lines cleared in one scan (4+ capped)
//   scan_state_e : row scanner FSM states
package tetris_pkg;

  parameter logic [15:0] BG_COLOR = 16'h0000;
  parameter int          ROWS     = 20;
  parameter int          COLS     = 10;

  parameter logic [10:0] SCORE_1 = 11'd40;
  parameter logic [10:0] SCORE_2 = 11'd100;
  parameter logic [10:0] SCORE_3 = 11'd300;
  parameter logic [10:0] SCORE_4 = 11'd1200;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EVAL,
    NEXT,
    FIN,
    ABORT
  } scan_state_e;

  // Points for a given number of full rows; anything beyond four pays the
  // four-line amount.
  function automatic logic [10:0] score_for(input logic [4:0] lines);
    case (lines)
      5'd0:    score_for = 11'd0;
      5'd1:    score_for = SCORE_1;
      5'd2:    score_for = SCORE_2;
      5'd3:    score_for = SCORE_3;
      default: score_for = SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/row_full_check.sv
// Combinational full-row detector.
//   words : COLS captured cell colour words of one row
//   full  : 1 when no word equals the background colour
module row_full_check
  import tetris_pkg::BG_COLOR;
#(
  parameter int COLS = tetris_pkg::COLS
) (
  input  logic [COLS-1:0][15:0] words,
  output logic                  full
);

  // NOTE: the output gets a default before the loop so every path assigns it;
  // without that default an always_comb infers a latch.
  always_comb begin
    full = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      if (words[i] == BG_COLOR) full = 1'b0;
    end
  end

endmodule

// File: rtl/row_scanner.sv
// Playfield row scanner: after a piece locks, requests each row from the
// row-read stage bottom to top, flags full rows, and reports score and a
// saturating line total. Unanswered requests are re-issued and eventually
// abort the scan.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : one-cycle scan request (ignored while busy)
//   row_ready    : row-read response pulse, read_reg valid with it
//   read_reg     : COLS x 16-bit cell colour words of the requested row
//   row_ld, row  : one-cycle row request and its (stable) row index
//   busy         : scan in progress
//   done, err    : one-cycle completion / abort pulses
//   full_rows    : bit r set when row r is full (valid from done)
//   full_count   : number of full rows
//   score_add    : points for this scan
//   lines_total  : running line total, saturating at 16'hFFFF
module row_scanner #(
  parameter int ROWS      = tetris_pkg::ROWS,
  parameter int COLS      = tetris_pkg::COLS,
  parameter int RETRY_CYC = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  row_ready,
  input  logic [COLS-1:0][15:0] read_reg,
  output logic                  row_ld,
  output logic [7:0]            row,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ROWS-1:0]       full_rows,
  output logic [4:0]            full_count,
  output logic [10:0]           score_add,
  output logic [15:0]           lines_total
);

  import tetris_pkg::scan_state_e, tetris_pkg::score_for;
  import tetris_pkg::IDLE, tetris_pkg::ISSUE, tetris_pkg::WAIT, tetris_pkg::EVAL;
  import tetris_pkg::NEXT, tetris_pkg::FIN, tetris_pkg::ABORT;

  localparam int TW = $clog2(RETRY_CYC);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int IW = $clog2(ROWS);

  scan_state_e           state;
  logic [TW-1:0]         timer;
  logic [RW-1:0]         retry;
  logic [COLS-1:0][15:0] row_buf;
  logic                  row_full;
  logic [16:0]           lines_sum;

  row_full_check #(.COLS(COLS)) u_full_check (
    .words (row_buf),
    .full  (row_full)
  );

  assign lines_sum = {1'b0, lines_total} + {12'd0, full_count};

  // The timer counts cycles since the current row_ld (0 in the ISSUE cycle),
  // so successive re-issues of one row are exactly RETRY_CYC cycles apart.
  // NOTE: all state here is assigned with non-blocking <= so every register
  // samples the pre-edge values; blocking = would create order dependence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      retry       <= '0;
      // NOTE: the row buffer is ordinary flops, not a RAM, so clearing it on
      // reset is cheap and keeps a stale row from ever being evaluated.
      row_buf     <= '0;
      row_ld      <= 1'b0;
      row         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      full_rows   <= '0;
      full_count  <= '0;
      score_add   <= '0;
      lines_total <= '0;
    end else begin
      row_ld <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          // row_ready arriving with start is deliberately not looked at here.
          if (start) begin
            full_rows  <= '0;
            full_count <= '0;
            row        <= 8'(ROWS - 1);
            retry      <= '0;
            timer      <= '0;
            busy       <= 1'b1;
            row_ld     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= timer + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (row_ready) begin
            row_buf <= read_reg;
            state   <= EVAL;
          end else if (timer == TW'(RETRY_CYC - 1)) begin
            if (retry == RW'(MAX_RETRY)) begin
              state <= ABORT;
            end else begin
              retry  <= retry + 1'b1;
              timer  <= '0;
              row_ld <= 1'b1;
              state  <= ISSUE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EVAL: begin
          if (row_full) begin
            full_rows[row[IW-1:0]] <= 1'b1;
            full_count             <= full_count + 5'd1;
          end
          state <= NEXT;
        end
        NEXT: begin
          if (row == '0) begin
            state <= FIN;
          end else begin
            row    <= row - 8'd1;
            retry  <= '0;
            timer  <= '0;
            row_ld <= 1'b1;
            state  <= ISSUE;
          end
        end
        FIN: begin
          score_add   <= score_for(full_count);
          lines_total <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        ABORT: begin
          err        <= 1'b1;
          full_rows  <= '0;
          full_count <= '0;
          score_add  <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_scanner.sv
// Self-checking bench for row_scanner: table of directed scans, randomized
// scans against a playfield model, retry/abort, saturation and reset corners.
module tb_row_scanner;

  localparam int ROWS      = 20;
  localparam int COLS      = 10;
  localparam int RETRY_CYC = 32;
  localparam int MAX_RETRY = 3;
  localparam int BUDGET    = 8000;

  typedef logic [COLS-1:0][15:0] row_t;

  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic             start     = 1'b0;
  logic             row_ready = 1'b0;
  row_t             read_reg  = '0;
  logic             row_ld;
  logic [7:0]       row;
  logic             busy;
  logic             done;
  logic             err;
  logic [ROWS-1:0]  full_rows;
  logic [4:0]       full_count;
  logic [10:0]      score_add;
  logic [15:0]      lines_total;

  row_scanner #(
    .ROWS(ROWS), .COLS(COLS), .RETRY_CYC(RETRY_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .row_ready(row_ready),
    .read_reg(read_reg), .row_ld(row_ld), .row(row), .busy(busy),
    .done(done), .err(err), .full_rows(full_rows), .full_count(full_count),
    .score_add(score_add), .lines_total(lines_total)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc++;

  // Playfield seen by the row-read model and the reference.
  row_t field [ROWS];

  // Row-read model configuration and request log.
  int k         = 5;
  int dead_row  = -1;
  bit spur_en   = 1'b0;
  bit inject    = 1'b0;
  typedef struct { int c; int r; } ld_t;
  ld_t ld_log[$];

  int lt_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row-read stage: answers each row_ld k cycles later (except dead_row),
  // optionally follows each answer with two spurious pulses of all-full data.
  initial begin
    int cnt  = 0;
    int prow = 0;
    int spur = 0;
    forever begin
      @(posedge clk);
      #2;
      row_ready = 1'b0;
      if (inject) begin
        row_ready = 1'b1;
        read_reg  = {COLS{16'hFFFF}};
        inject    = 1'b0;
      end
      if (spur > 0) begin
        spur--;
        row_ready = 1'b1;
        read_reg  = {COLS{16'hFFFF}};
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          row_ready = 1'b1;
          read_reg  = field[prow];
          if (spur_en) spur = 2;
        end
      end
      if (row_ld) begin
        ld_log.push_back('{cyc, int'(row)});
        if (int'(row) != dead_row) begin
          cnt  = k;
          prow = int'(row);
        end
      end
    end
  end

  // Full rows get non-background words; other rows get one background word.
  task automatic fill_field(input logic [ROWS-1:0] mask, input logic [15:0] word, input bit blank);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (blank)            field[r][c] = 16'h0000;
        else if (word != '0)  field[r][c] = word;
        else                  field[r][c] = 16'($urandom_range(1, 16'hFFFF));
      end
      if (!blank && !mask[r]) field[r][$urandom_range(0, COLS - 1)] = 16'h0000;
    end
  endtask

  // Reference: a row is full when none of its cells holds the background colour.
  function automatic logic [ROWS-1:0] model_mask();
    logic [ROWS-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) begin
      m[r] = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (field[r][c] == 16'h0000) m[r] = 1'b0;
    end
    return m;
  endfunction

  function automatic int model_score(input int lines);
    int pts[5] = '{0, 40, 100, 300, 1200};
    return pts[(lines > 4) ? 4 : lines];
  endfunction

  task automatic run_scan(input int kk, input int dead, input bit busy_starts, input bit spur,
                          input string tag, output int t0, output int lat,
                          output bit got_err, output bit busy1);
    k        = kk;
    dead_row = dead;
    spur_en  = spur;
    ld_log.delete();
    start = 1'b1;
    t0    = cyc;
    tick();
    start   = 1'b0;
    busy1   = busy;
    lat     = -1;
    got_err = 1'b0;
    for (int n = 0; n < BUDGET && lat < 0; n++) begin
      if (done || err) begin
        lat     = cyc - t0;
        got_err = err;
      end else begin
        start = busy_starts && (n % 5 == 2);
        tick();
      end
    end
    start = 1'b0;
    check({tag, " scan terminated"}, lat >= 0, 1'b1);
  endtask

  task automatic scan_and_check(input int kk, input int dead, input bit busy_starts, input bit spur,
                                input logic [ROWS-1:0] exp_mask, input int exp_cnt,
                                input int exp_score, input string tag);
    int t0, lat, t;
    bit got_err, busy1, seq_ok;
    int exp_rows[$];
    int exp_cyc[$];
    run_scan(kk, dead, busy_starts, spur, tag, t0, lat, got_err, busy1);
    check({tag, " busy after start"}, busy1, 1'b1);
    if (dead < 0) begin
      check({tag, " done latency"}, lat, ROWS * (kk + 3) + 2);
      check({tag, " err"}, got_err, 1'b0);
      check({tag, " full_rows"}, full_rows, exp_mask);
      check({tag, " full_count"}, full_count, exp_cnt);
      check({tag, " score_add"}, score_add, exp_score);
      lt_model = (lt_model + exp_cnt > 65535) ? 65535 : lt_model + exp_cnt;
    end else begin
      check({tag, " err seen"}, got_err, 1'b1);
      check({tag, " full_rows cleared"}, full_rows, 0);
      check({tag, " full_count cleared"}, full_count, 0);
      check({tag, " score_add cleared"}, score_add, 0);
    end
    check({tag, " lines_total"}, lines_total, lt_model);
    check({tag, " busy at end"}, busy, 1'b0);

    t = t0 + 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (r == dead) begin
        for (int i = 0; i <= MAX_RETRY; i++) begin
          exp_rows.push_back(r);
          exp_cyc.push_back(t);
          t += RETRY_CYC;
        end
        break;
      end
      exp_rows.push_back(r);
      exp_cyc.push_back(t);
      t += kk + 3;
    end
    check({tag, " row_ld count"}, ld_log.size(), exp_rows.size());
    seq_ok = (ld_log.size() == exp_rows.size());
    for (int i = 0; i < ld_log.size() && seq_ok; i++)
      if (ld_log[i].r != exp_rows[i] || ld_log[i].c != exp_cyc[i]) seq_ok = 1'b0;
    check({tag, " row_ld order and timing"}, seq_ok, 1'b1);

    tick();
    check({tag, " done/err single cycle"}, {done, err}, 2'b00);
  endtask

  typedef struct {
    logic [ROWS-1:0] mask;
    logic [15:0]     word;
    bit              blank;
    int              kk;
    int              cnt;
    int              score;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [ROWS-1:0] m;
    int              kk;
    bit              seen;

    tbl[0] = '{20'h00000, 16'h0000, 1'b1, 5, 0,  0};
    tbl[1] = '{20'hF0000, 16'h0F00, 1'b0, 5, 4,  1200};
    tbl[2] = '{20'h00001, 16'h0000, 1'b0, 1, 1,  40};
    tbl[3] = '{20'h80001, 16'h0000, 1'b0, 2, 2,  100};
    tbl[4] = '{20'h01500, 16'h0000, 1'b0, 3, 3,  300};
    tbl[5] = '{20'h0003F, 16'h0000, 1'b0, 4, 6,  1200};
    tbl[6] = '{20'hFFFFF, 16'h0000, 1'b0, 1, 20, 1200};
    tbl[7] = '{20'h00400, 16'h1234, 1'b0, 7, 1,  40};

    // Reset state.
    tick();
    check("reset row_ld", row_ld, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset row", row, 0);
    check("reset full_rows", full_rows, 0);
    check("reset full_count", full_count, 0);
    check("reset score_add", score_add, 0);
    check("reset lines_total", lines_total, 0);
    reset = 1'b1;
    tick();

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      fill_field(tbl[i].mask, tbl[i].word, tbl[i].blank);
      scan_and_check(tbl[i].kk, -1, 1'b0, 1'b0, tbl[i].mask, tbl[i].cnt, tbl[i].score,
                     $sformatf("table%0d", i));
    end

    // Randomized scans against the playfield model.
    for (int i = 0; i < 16; i++) begin
      m = ROWS'($urandom);
      if ($urandom_range(0, 1) == 1) m &= ROWS'($urandom);
      kk = $urandom_range(1, 6);
      fill_field(m, 16'h0000, 1'b0);
      m = model_mask();
      scan_and_check(kk, -1, 1'b0, 1'b0, m, $countones(m), model_score($countones(m)),
                     $sformatf("rand%0d", i));
    end

    // Row 10 never answered: four requests, then abort.
    fill_field(20'hC0000, 16'h0000, 1'b0);
    scan_and_check(3, 10, 1'b0, 1'b0, '0, 0, 0, "abort");

    // start while busy and spurious row_ready after each answer.
    fill_field(20'h30C05, 16'h0000, 1'b0);
    m = model_mask();
    scan_and_check(4, -1, 1'b1, 1'b1, m, $countones(m), model_score($countones(m)), "spurious");

    // start together with row_ready while idle.
    fill_field(20'h00102, 16'h0000, 1'b0);
    m = model_mask();
    inject = 1'b1;
    scan_and_check(2, -1, 1'b0, 1'b0, m, $countones(m), model_score($countones(m)), "start+ready");

    // Saturation: reaching FFFE by scans would take ~270k cycles, so the
    // running total is deposited directly, then real scans push it over.
    dut.lines_total <= 16'hFFFE;
    lt_model = 16'hFFFE;
    tick();
    fill_field(20'h00007, 16'h0000, 1'b0);
    scan_and_check(1, -1, 1'b0, 1'b0, 20'h00007, 3, 300, "saturate");
    fill_field(20'h60000, 16'h0000, 1'b0);
    scan_and_check(1, -1, 1'b0, 1'b0, 20'h60000, 2, 100, "saturated");

    // Reset while waiting on row 12.
    fill_field(20'h00000, 16'h0000, 1'b0);
    k        = 3;
    dead_row = 12;
    spur_en  = 1'b0;
    ld_log.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      tick();
      seen = (ld_log.size() > 0) && (ld_log[ld_log.size() - 1].r == 12);
    end
    check("midreset reached row 12", seen, 1'b1);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("midreset row_ld", row_ld, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset err", err, 0);
    check("midreset row", row, 0);
    check("midreset full_rows", full_rows, 0);
    check("midreset full_count", full_count, 0);
    check("midreset score_add", score_add, 0);
    check("midreset lines_total", lines_total, 0);
    reset    = 1'b1;
    lt_model = 0;
    tick();
    fill_field(20'h0C003, 16'h0000, 1'b0);
    m = model_mask();
    scan_and_check(2, -1, 1'b0, 1'b0, m, $countones(m), model_score($countones(m)), "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/row_scanner.md
ROW_SCANNER -- requirements
Module: row_scanner

Interface
REQ-001 Parameter: ROWS, 20, playfield rows scanned.
REQ-002 Parameter: COLS, 10, words per row delivered by the row-read stage.
REQ-003 Parameter: RETRY_CYC, 1024, cycles to wait for row_ready before re-issuing a row request.
REQ-004 Parameter: MAX_RETRY, 3, re-issues per row before abort.
REQ-005 Port: clk  in  1  sole clock.
REQ-006 Port: reset  in  1  asynchronous, active-low reset.
REQ-007 Port: start  in  1  one-cycle request to scan the playfield, issued after a piece locks.
REQ-008 Port: row_ready  in  1  one-cycle pulse from the row-read stage; read_reg is valid in the same cycle.
REQ-009 Port: read_reg  in  16 x COLS  one row of cell colour words.
REQ-010 Port: row_ld  out  1  one-cycle row-read request to the row-read stage.
REQ-011 Port: row  out  8  row index for row_ld; held stable while a request is outstanding.
REQ-012 Port: busy  out  1  high from start acceptance until done or err.
REQ-013 Port: done  out  1  one-cycle pulse; scan completed.
REQ-014 Port: err  out  1  one-cycle pulse; scan aborted after MAX_RETRY.
REQ-015 Port: full_rows  out  ROWS  bit r set when row r is full; valid from done until next start.
REQ-016 Port: full_count  out  5  number of set bits in full_rows.
REQ-017 Port: score_add  out  11  points for this scan.
REQ-018 Port: lines_total  out  16  saturating running total of cleared lines.

Function
REQ-019 States: IDLE, ISSUE, WAIT, EVAL, NEXT, FIN, ABORT.
REQ-020 IDLE: start=1 -> clear full_rows/full_count, row <= ROWS-1, retry count 0, busy <= 1, go ISSUE; start while busy ignored.
REQ-021 ISSUE: row_ld=1 for exactly one cycle, wait timer 0, go WAIT.
REQ-022 WAIT: row_ready=1 -> capture all COLS words of read_reg into internal row buffer, go EVAL.
REQ-023 WAIT: timer reaches RETRY_CYC-1 without row_ready -> retry+1 and go ISSUE (same row); if retry already MAX_RETRY -> go ABORT.
REQ-024 row_ready outside WAIT ignored (stale pulse never captured).
REQ-025 EVAL: row full iff every captured word != BG_COLOR; full -> set full_rows[row], full_count+1; go NEXT.
REQ-026 NEXT: row==0 -> go FIN; else row-1, retry 0, go ISSUE.
REQ-027 Scan order bottom (ROWS-1) to top (0); a row request never issued before previous row evaluated.
REQ-028 FIN: score_add per count 0/1/2/3/4 = 0/40/100/300/1200, count>4 -> 1200; lines_total += full_count saturating at 16'hFFFF; done=1 one cycle; busy <= 0; go IDLE.
REQ-029 ABORT: err=1 one cycle, full_rows/full_count/score_add cleared, lines_total unchanged, busy <= 0, go IDLE.
REQ-030 Nominal latency start->done with zero retries and row_ready k cycles after row_ld: ROWS*(k+3)+2 cycles.
REQ-031 start and row_ready in same cycle while IDLE: start accepted, row_ready ignored.

Reset
REQ-032 reset low -> state IDLE; row_ld, busy, done, err 0; row 0; full_rows, full_count, score_add, lines_total 0; internal timers, retry count, row buffer 0.
REQ-033 Reset mid-scan aborts immediately without done/err; no partial results retained.

Structure
REQ-034 Shared package tetris_pkg holds BG_COLOR (16'h0000), ROWS, COLS, score table constants and the state enum type.
REQ-035 One sub-module row_full_check: combinational COLS-word compare against BG_COLOR producing a single full flag.

Verification
REQ-036 Empty field, row_ready 5 cycles after each row_ld -> 20 row_ld pulses rows 19..0, done at cycle 162, full_rows=0, score_add=0.
REQ-037 Rows 19,18,17,16 all words 16'h0F00, rest with one BG word -> full_rows=20'hF0000, full_count=4, score_add=1200, lines_total=4.
REQ-038 Row 10 never answered -> row_ld for row 10 issued 4 times RETRY_CYC apart, then err pulse, busy low, lines_total unchanged.
REQ-039 lines_total preloaded via repeated scans to 16'hFFFE, then scan with 3 full rows -> lines_total=16'hFFFF.
REQ-040 reset low during WAIT on row 12 -> all outputs 0 next cycle; subsequent start scans normally from row 19.
REQ-041 start pulsed while busy and spurious row_ready during EVAL -> no rescan, no extra capture, results match single-scan reference.
